// File: rtl/multi_issue_engine.sv
// Decode-stage issue detector. It picks how many of the oldest slots issue together
// and tracks in-flight load destinations in a per-register countdown scoreboard.
module multi_issue_engine #(
    parameter int ISSUE_WIDTH  = 2,
    parameter int LOAD_LATENCY = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter int PERF_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               flush,
    input  logic                               stall,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    input  logic [6*ISSUE_WIDTH-1:0]           slot_opcode,
    input  logic [5*ISSUE_WIDTH-1:0]           slot_rs,
    input  logic [5*ISSUE_WIDTH-1:0]           slot_rt,
    input  logic [5*ISSUE_WIDTH-1:0]           slot_dest,
    input  logic [ISSUE_WIDTH-1:0]             slot_wb_en,
    input  logic [2*ISSUE_WIDTH-1:0]           slot_mem_type,
    input  logic [ISSUE_WIDTH-1:0]             slot_branch,
    input  logic [ISSUE_WIDTH-1:0]             slot_priv,
    input  logic [ISSUE_WIDTH-1:0]             slot_hilo,
    output logic [ISSUE_WIDTH-1:0]             issue_mask,
    output logic [$clog2(ISSUE_WIDTH+1)-1:0]   issue_count,
    output logic                               load_use_stall,
    output logic [PERF_WIDTH-1:0]              perf_multi_cnt,
    output logic [PERF_WIDTH-1:0]              perf_single_cnt,
    output logic [PERF_WIDTH-1:0]              perf_stall_cnt
);

    localparam int SB_W  = $clog2(LOAD_LATENCY + 1);
    localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);

    // Memory-type encoding shared with common.vh.
    localparam logic [1:0] MEM_NOOP = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;

    logic [5:0]      op    [ISSUE_WIDTH];
    logic [4:0]      rs    [ISSUE_WIDTH];
    logic [4:0]      rt    [ISSUE_WIDTH];
    logic [4:0]      dest  [ISSUE_WIDTH];
    logic [1:0]      mem   [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] src_blocked;

    logic [SB_W-1:0] sb_cnt  [32];
    logic [SB_W-1:0] sb_next [32];
    logic [31:0]     busy;

    logic            prev_ok;
    logic            ok;
    logic            priv_seen;
    int              issue_total;
    logic            slot0_flags_unused;

    assign slot0_flags_unused = slot_branch[0] ^ slot_hilo[0];

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            op[k]   = slot_opcode[6*k +: 6];
            rs[k]   = slot_rs[5*k +: 5];
            rt[k]   = slot_rt[5*k +: 5];
            dest[k] = slot_dest[5*k +: 5];
            mem[k]  = slot_mem_type[2*k +: 2];
        end
    end

    // rt is only a source for R-type (opcode 0) instructions.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            busy[r] = (sb_cnt[r] != '0);
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            src_blocked[k] = busy[rs[k]] || ((op[k] == 6'd0) && busy[rt[k]]);
        end
    end

    always_comb begin
        issue_mask  = '0;
        issue_total = 0;
        ok          = 1'b0;
        prev_ok     = (int'(fifo_count) >= 1) && !stall && !src_blocked[0];
        priv_seen   = slot_priv[0];
        issue_mask[0] = prev_ok;
        for (int k = 1; k < ISSUE_WIDTH; k++) begin
            ok = prev_ok && (int'(fifo_count) > k) && !priv_seen
                 && !slot_priv[k] && !slot_branch[k] && !slot_hilo[k]
                 && (mem[k] == MEM_NOOP) && !src_blocked[k];
            for (int j = 0; j < k; j++) begin
                if (slot_wb_en[j] && (dest[j] != 5'd0)) begin
                    if (dest[j] == rs[k]) ok = 1'b0;
                    if ((op[k] == 6'd0) && (dest[j] == rt[k])) ok = 1'b0;
                    if (slot_wb_en[k] && (dest[j] == dest[k])) ok = 1'b0;
                end
            end
            issue_mask[k] = ok;
            prev_ok       = ok;
            priv_seen     = priv_seen | slot_priv[k];
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (issue_mask[k]) issue_total++;
        end
    end

    assign issue_count    = CNT_W'(issue_total);
    assign load_use_stall = (fifo_count != '0) && !stall && src_blocked[0];

    // Decrement first; a newly issued load then overrides its destination entry.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            sb_next[r] = (sb_cnt[r] != '0) ? sb_cnt[r] - SB_W'(1) : '0;
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (issue_mask[k] && (mem[k] == MEM_LOAD) && slot_wb_en[k] && (dest[k] != 5'd0)) begin
                sb_next[dest[k]] = SB_W'(LOAD_LATENCY);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < 32; r++) sb_cnt[r] <= '0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) sb_cnt[r] <= '0;
        end else if (!stall) begin
            for (int r = 0; r < 32; r++) sb_cnt[r] <= sb_next[r];
        end
    end

    // Perf counters observe every cycle regardless of stall/flush and simply wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_multi_cnt  <= '0;
            perf_single_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (issue_total >= 2) perf_multi_cnt <= perf_multi_cnt + PERF_WIDTH'(1);
            if (issue_total == 1) perf_single_cnt <= perf_single_cnt + PERF_WIDTH'(1);
            if ((fifo_count != '0) && (issue_total == 0)) perf_stall_cnt <= perf_stall_cnt + PERF_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_multi_issue_engine.sv
// Directed bench for multi_issue_engine: a 2-wide and a 4-wide instance share
// clock, reset, flush, stall and fifo_count; each test drives the instance it targets.
module tb_multi_issue_engine;

    localparam logic [1:0] MEM_NOOP = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;
    localparam logic [5:0] OP_ADDU  = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;

    int checks = 0;
    int errors = 0;

    logic       clk = 1'b0;
    logic       resetn, flush, stall;
    logic [4:0] fifo_count;

    logic [11:0] a_op;
    logic [9:0]  a_rs, a_rt, a_dest;
    logic [3:0]  a_mem;
    logic [1:0]  a_wb, a_br, a_priv, a_hilo, a_mask, a_cnt;
    logic        a_lus;
    logic [31:0] a_multi, a_single, a_stallc;

    logic [23:0] b_op;
    logic [19:0] b_rs, b_rt, b_dest;
    logic [7:0]  b_mem;
    logic [3:0]  b_wb, b_br, b_priv, b_hilo, b_mask;
    logic [2:0]  b_cnt;
    logic        b_lus;
    logic [31:0] b_multi, b_single, b_stallc;

    always #5 clk = ~clk;

    multi_issue_engine #(.ISSUE_WIDTH(2), .LOAD_LATENCY(2), .FIFO_DEPTH(16), .PERF_WIDTH(32)) dut_w2 (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall), .fifo_count(fifo_count),
        .slot_opcode(a_op), .slot_rs(a_rs), .slot_rt(a_rt), .slot_dest(a_dest),
        .slot_wb_en(a_wb), .slot_mem_type(a_mem), .slot_branch(a_br), .slot_priv(a_priv),
        .slot_hilo(a_hilo), .issue_mask(a_mask), .issue_count(a_cnt), .load_use_stall(a_lus),
        .perf_multi_cnt(a_multi), .perf_single_cnt(a_single), .perf_stall_cnt(a_stallc)
    );

    multi_issue_engine #(.ISSUE_WIDTH(4), .LOAD_LATENCY(2), .FIFO_DEPTH(16), .PERF_WIDTH(32)) dut_w4 (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall), .fifo_count(fifo_count),
        .slot_opcode(b_op), .slot_rs(b_rs), .slot_rt(b_rt), .slot_dest(b_dest),
        .slot_wb_en(b_wb), .slot_mem_type(b_mem), .slot_branch(b_br), .slot_priv(b_priv),
        .slot_hilo(b_hilo), .issue_mask(b_mask), .issue_count(b_cnt), .load_use_stall(b_lus),
        .perf_multi_cnt(b_multi), .perf_single_cnt(b_single), .perf_stall_cnt(b_stallc)
    );

    task automatic clear_a();
        a_op = '0; a_rs = '0; a_rt = '0; a_dest = '0; a_mem = '0;
        a_wb = '0; a_br = '0; a_priv = '0; a_hilo = '0;
    endtask

    task automatic clear_b();
        b_op = '0; b_rs = '0; b_rt = '0; b_dest = '0; b_mem = '0;
        b_wb = '0; b_br = '0; b_priv = '0; b_hilo = '0;
    endtask

    task automatic put_a(input int k, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dest, input logic wb, input logic [1:0] mem);
        a_op[6*k +: 6] = op; a_rs[5*k +: 5] = rs; a_rt[5*k +: 5] = rt;
        a_dest[5*k +: 5] = dest; a_wb[k] = wb; a_mem[2*k +: 2] = mem;
    endtask

    task automatic put_b(input int k, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dest, input logic wb, input logic [1:0] mem);
        b_op[6*k +: 6] = op; b_rs[5*k +: 5] = rs; b_rt[5*k +: 5] = rt;
        b_dest[5*k +: 5] = dest; b_wb[k] = wb; b_mem[2*k +: 2] = mem;
    endtask

    // Called at a negedge; returns at the negedge right after reset release.
    task automatic do_reset();
        flush = 1'b0; stall = 1'b0; fifo_count = '0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; stall = 1'b0; fifo_count = '0;
        clear_a(); clear_b();
        @(negedge clk); #1;
        checks++; if (a_mask !== 2'b00) begin errors++; $display("[TB] FAIL rst_mask got %b want 00", a_mask); end
        checks++; if (a_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rst_count got %0d want 0", a_cnt); end
        checks++; if (a_single !== 32'd0 || a_stallc !== 32'd0 || a_multi !== 32'd0) begin
            errors++; $display("[TB] FAIL rst_perf got %0d/%0d/%0d want 0/0/0", a_multi, a_single, a_stallc); end
        @(negedge clk);
        resetn = 1'b1;
        fifo_count = 5'd1;
        put_a(0, OP_LW, 5'd1, 5'd5, 5'd5, 1'b1, MEM_LOAD);
        @(negedge clk);
        put_a(0, OP_ADDU, 5'd5, 5'd1, 5'd6, 1'b1, MEM_NOOP);
        #1;
        checks++; if (a_lus !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_lus got %b want 1", a_lus); end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (a_lus !== 1'b0) begin errors++; $display("[TB] FAIL midrst_lus got %b want 0", a_lus); end
        checks++; if (a_mask !== 2'b01) begin errors++; $display("[TB] FAIL midrst_mask got %b want 01", a_mask); end
        checks++; if (a_single !== 32'd0 || a_stallc !== 32'd0) begin
            errors++; $display("[TB] FAIL midrst_perf got single %0d stall %0d want 0 0", a_single, a_stallc); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (a_cnt !== 2'd1) begin errors++; $display("[TB] FAIL post_rst_count got %0d want 1", a_cnt); end
        @(negedge clk); #1;
        checks++; if (a_single !== 32'd1 || a_stallc !== 32'd0) begin
            errors++; $display("[TB] FAIL post_rst_perf got single %0d stall %0d want 1 0", a_single, a_stallc); end
    endtask

    task automatic test_load_use();
        do_reset(); clear_a();
        fifo_count = 5'd1;
        put_a(0, OP_LW, 5'd1, 5'd5, 5'd5, 1'b1, MEM_LOAD);
        #1;
        checks++; if (a_cnt !== 2'd1) begin errors++; $display("[TB] FAIL lu_load_count got %0d want 1", a_cnt); end
        @(negedge clk);
        put_a(0, OP_ADDU, 5'd5, 5'd1, 5'd6, 1'b1, MEM_NOOP);
        #1;
        checks++; if (a_lus !== 1'b1 || a_cnt !== 2'd0) begin
            errors++; $display("[TB] FAIL lu_cycle1 got lus %b count %0d want 1 0", a_lus, a_cnt); end
        @(negedge clk); #1;
        checks++; if (a_lus !== 1'b1) begin errors++; $display("[TB] FAIL lu_cycle2 got lus %b want 1", a_lus); end
        @(negedge clk); #1;
        checks++; if (a_lus !== 1'b0 || a_cnt !== 2'd1) begin
            errors++; $display("[TB] FAIL lu_cycle3 got lus %b count %0d want 0 1", a_lus, a_cnt); end
        @(negedge clk);
        put_a(0, OP_LW, 5'd1, 5'd0, 5'd0, 1'b1, MEM_LOAD);
        @(negedge clk);
        put_a(0, OP_ADDU, 5'd0, 5'd0, 5'd6, 1'b1, MEM_NOOP);
        #1;
        checks++; if (a_lus !== 1'b0 || a_cnt !== 2'd1) begin
            errors++; $display("[TB] FAIL lu_reg0 got lus %b count %0d want 0 1", a_lus, a_cnt); end
        @(negedge clk); #1;
        checks++; if (a_single !== 32'd4 || a_stallc !== 32'd2) begin
            errors++; $display("[TB] FAIL lu_perf got single %0d stall %0d want 4 2", a_single, a_stallc); end
    endtask

    task automatic test_raw_waw();
        do_reset(); clear_a();
        fifo_count = 5'd2;
        put_a(0, OP_ADDU, 5'd1, 5'd2, 5'd3, 1'b1, MEM_NOOP);
        put_a(1, OP_ADDU, 5'd3, 5'd2, 5'd4, 1'b1, MEM_NOOP);
        #1;
        checks++; if (a_mask !== 2'b01 || a_cnt !== 2'd1) begin
            errors++; $display("[TB] FAIL raw_rs got mask %b count %0d want 01 1", a_mask, a_cnt); end
        @(negedge clk);
        put_a(1, OP_ADDU, 5'd7, 5'd2, 5'd4, 1'b1, MEM_NOOP);
        #1;
        checks++; if (a_mask !== 2'b11 || a_cnt !== 2'd2) begin
            errors++; $display("[TB] FAIL indep_pair got mask %b count %0d want 11 2", a_mask, a_cnt); end
        @(negedge clk);
        put_a(1, OP_ADDU, 5'd7, 5'd3, 5'd4, 1'b1, MEM_NOOP);
        #1;
        checks++; if (a_multi !== 32'd1 || a_single !== 32'd1) begin
            errors++; $display("[TB] FAIL raw_perf got multi %0d single %0d want 1 1", a_multi, a_single); end
        checks++; if (a_mask !== 2'b01) begin errors++; $display("[TB] FAIL raw_rt got mask %b want 01", a_mask); end
        @(negedge clk);
        put_a(1, OP_ADDIU, 5'd7, 5'd3, 5'd8, 1'b1, MEM_NOOP);
        #1;
        checks++; if (a_mask !== 2'b11) begin errors++; $display("[TB] FAIL itype_rt got mask %b want 11", a_mask); end
        @(negedge clk);
        put_a(1, OP_ADDU, 5'd7, 5'd2, 5'd3, 1'b1, MEM_NOOP);
        #1;
        checks++; if (a_mask !== 2'b01) begin errors++; $display("[TB] FAIL waw got mask %b want 01", a_mask); end
        @(negedge clk);
        put_a(1, OP_ADDU, 5'd7, 5'd2, 5'd3, 1'b0, MEM_NOOP);
        #1;
        checks++; if (a_mask !== 2'b11) begin errors++; $display("[TB] FAIL waw_nowb got mask %b want 11", a_mask); end
        @(negedge clk);
        put_a(0, OP_ADDU, 5'd1, 5'd2, 5'd0, 1'b1, MEM_NOOP);
        put_a(1, OP_ADDU, 5'd0, 5'd2, 5'd4, 1'b1, MEM_NOOP);
        #1;
        checks++; if (a_mask !== 2'b11) begin errors++; $display("[TB] FAIL raw_reg0 got mask %b want 11", a_mask); end
        @(negedge clk);
    endtask

    task automatic test_fifo_limit();
        do_reset(); clear_b();
        for (int k = 0; k < 4; k++) put_b(k, OP_ADDU, 5'd1, 5'd2, 5'(10 + k), 1'b1, MEM_NOOP);
        fifo_count = 5'd3;
        #1;
        checks++; if (b_mask !== 4'b0111 || b_cnt !== 3'd3) begin
            errors++; $display("[TB] FAIL fifo3 got mask %b count %0d want 0111 3", b_mask, b_cnt); end
        @(negedge clk);
        fifo_count = 5'd4;
        #1;
        checks++; if (b_mask !== 4'b1111 || b_cnt !== 3'd4) begin
            errors++; $display("[TB] FAIL fifo4 got mask %b count %0d want 1111 4", b_mask, b_cnt); end
        @(negedge clk);
        fifo_count = 5'd0;
        #1;
        checks++; if (b_mask !== 4'b0000 || b_cnt !== 3'd0) begin
            errors++; $display("[TB] FAIL fifo0 got mask %b count %0d want 0000 0", b_mask, b_cnt); end
        @(negedge clk);
        fifo_count = 5'd1;
        #1;
        checks++; if (b_mask !== 4'b0001) begin errors++; $display("[TB] FAIL fifo1 got mask %b want 0001", b_mask); end
        @(negedge clk); #1;
        checks++; if (b_multi !== 32'd2 || b_single !== 32'd1 || b_stallc !== 32'd0) begin
            errors++; $display("[TB] FAIL fifo_perf got %0d/%0d/%0d want 2/1/0", b_multi, b_single, b_stallc); end
    endtask

    task automatic test_branch_priv();
        do_reset(); clear_b();
        for (int k = 0; k < 4; k++) put_b(k, OP_ADDU, 5'd1, 5'd2, 5'(10 + k), 1'b1, MEM_NOOP);
        fifo_count = 5'd4;
        b_br = 4'b0100;
        #1;
        checks++; if (b_mask !== 4'b0011) begin errors++; $display("[TB] FAIL branch2 got mask %b want 0011", b_mask); end
        @(negedge clk);
        b_br = 4'b0000; b_priv = 4'b0001;
        #1;
        checks++; if (b_mask !== 4'b0001) begin errors++; $display("[TB] FAIL priv0 got mask %b want 0001", b_mask); end
        @(negedge clk);
        b_priv = 4'b0000; b_hilo = 4'b0010;
        #1;
        checks++; if (b_mask !== 4'b0001) begin errors++; $display("[TB] FAIL hilo1 got mask %b want 0001", b_mask); end
        @(negedge clk);
        b_hilo = 4'b0000; b_mem[7:6] = MEM_LOAD;
        #1;
        checks++; if (b_mask !== 4'b0111) begin errors++; $display("[TB] FAIL load3 got mask %b want 0111", b_mask); end
        @(negedge clk);
        b_mem = '0; b_br = 4'b0001;
        #1;
        checks++; if (b_mask !== 4'b1111) begin errors++; $display("[TB] FAIL branch0 got mask %b want 1111", b_mask); end
        @(negedge clk);
        b_br = 4'b0000;
        put_b(3, OP_ADDU, 5'd10, 5'd2, 5'd13, 1'b1, MEM_NOOP);
        #1;
        checks++; if (b_mask !== 4'b0111) begin errors++; $display("[TB] FAIL raw_0to3 got mask %b want 0111", b_mask); end
        @(negedge clk);
        put_b(3, OP_ADDU, 5'd1, 5'd2, 5'd13, 1'b1, MEM_NOOP);
        b_priv = 4'b1000;
        #1;
        checks++; if (b_mask !== 4'b0111) begin errors++; $display("[TB] FAIL priv3 got mask %b want 0111", b_mask); end
        @(negedge clk);
        b_priv = 4'b0000;
    endtask

    task automatic test_flush_stall();
        do_reset(); clear_a();
        fifo_count = 5'd1;
        put_a(0, OP_LW, 5'd1, 5'd5, 5'd5, 1'b1, MEM_LOAD);
        @(negedge clk);
        put_a(0, OP_ADDU, 5'd5, 5'd1, 5'd6, 1'b1, MEM_NOOP);
        flush = 1'b1;
        #1;
        checks++; if (a_lus !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre got lus %b want 1", a_lus); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (a_lus !== 1'b0 || a_cnt !== 2'd1) begin
            errors++; $display("[TB] FAIL flush_post got lus %b count %0d want 0 1", a_lus, a_cnt); end
        @(negedge clk);
        put_a(0, OP_LW, 5'd1, 5'd5, 5'd5, 1'b1, MEM_LOAD);
        @(negedge clk);
        put_a(0, OP_ADDU, 5'd5, 5'd1, 5'd6, 1'b1, MEM_NOOP);
        stall = 1'b1;
        #1;
        checks++; if (a_cnt !== 2'd0 || a_lus !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_gate got count %0d lus %b want 0 0", a_cnt, a_lus); end
        repeat (3) @(negedge clk);
        stall = 1'b0;
        #1;
        checks++; if (a_lus !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold1 got lus %b want 1", a_lus); end
        @(negedge clk); #1;
        checks++; if (a_lus !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold2 got lus %b want 1", a_lus); end
        @(negedge clk); #1;
        checks++; if (a_lus !== 1'b0 || a_cnt !== 2'd1) begin
            errors++; $display("[TB] FAIL stall_release got lus %b count %0d want 0 1", a_lus, a_cnt); end
        @(negedge clk); #1;
        checks++; if (a_single !== 32'd4 || a_stallc !== 32'd6 || a_multi !== 32'd0) begin
            errors++; $display("[TB] FAIL fs_perf got %0d/%0d/%0d want 0/4/6", a_multi, a_single, a_stallc); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_raw_waw();
        test_fifo_limit();
        test_branch_priv();
        test_flush_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_issue_engine.md
Name: multi_issue_engine

Overview:
Parametrised N-way issue-detect engine for the decode stage. It sits between the instruction FIFO and the ID/EX registers and decides, each cycle, how many of the oldest ISSUE_WIDTH decoded instructions issue together. Issue is always a contiguous prefix of the slots. It keeps a per-register load scoreboard, so load-use hazards of configurable latency are detected internally instead of being taken from a single ID/EX snapshot. It also keeps issue-width performance counters.

Parameters:
ISSUE_WIDTH, 2, number of decode slots examined per cycle (1..4); slot 0 is the oldest.
LOAD_LATENCY, 2, cycles after issue of a load before its destination may be read by a newly issued instruction (1..7).
FIFO_DEPTH, 16, instruction FIFO depth; sizes fifo_count.
PERF_WIDTH, 32, width of each performance counter.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (branch mispredict / exception); clears the scoreboard
stall  in  1  downstream stall; nothing issues and the scoreboard freezes
fifo_count  in  $clog2(FIFO_DEPTH+1)  valid instructions currently in the FIFO
slot_opcode  in  6*ISSUE_WIDTH  opcode of each slot
slot_rs  in  5*ISSUE_WIDTH  rs field of each slot
slot_rt  in  5*ISSUE_WIDTH  rt field of each slot
slot_dest  in  5*ISSUE_WIDTH  writeback register of each slot
slot_wb_en  in  ISSUE_WIDTH  writeback enable of each slot
slot_mem_type  in  2*ISSUE_WIDTH  memory type (`MEM_NOOP/`MEM_LOAD/... from common.vh)
slot_branch  in  ISSUE_WIDTH  slot is a branch/jump
slot_priv  in  ISSUE_WIDTH  slot is a privileged instruction
slot_hilo  in  ISSUE_WIDTH  slot accesses HI/LO
issue_mask  out  ISSUE_WIDTH  thermometer mask of the issuing slots
issue_count  out  $clog2(ISSUE_WIDTH+1)  popcount of issue_mask
load_use_stall  out  1  slot 0 is blocked by the scoreboard
perf_multi_cnt  out  PERF_WIDTH  cycles with issue_count >= 2
perf_single_cnt  out  PERF_WIDTH  cycles with issue_count == 1
perf_stall_cnt  out  PERF_WIDTH  cycles with fifo_count != 0 && issue_count == 0

Behaviour:
- Combinational issue decision; registered state is the scoreboard and the perf counters.
- Reset (resetn low, asynchronous): all scoreboard counters = 0 and all perf counters = 0. The outputs then settle to issue_mask=0 / issue_count=0 when fifo_count==0.
- Scoreboard: 32 counters, each $clog2(LOAD_LATENCY+1) bits; register 0 is never tracked.
- A register is busy when its counter is nonzero.
- On a clock edge with !stall && !flush:
  - every nonzero counter decrements by 1;
  - then, for each issued slot with mem_type==`MEM_LOAD, wb_en=1 and dest!=0, that register's counter is set to LOAD_LATENCY. The load set overrides the decrement.
- flush: all counters are cleared to 0 on that edge, with priority over everything else.
- stall (without flush): counters hold.
- Slot 0 issues iff all of the following hold; otherwise issue_mask=0:
  - fifo_count>=1;
  - !stall;
  - rs is not busy;
  - if opcode==0, rt is not busy.
- load_use_stall = fifo_count>=1 && !stall && slot 0 blocked by the scoreboard.
- Slot k (k>=1) issues iff all of the following hold:
  - slot k-1 issues;
  - fifo_count>k;
  - slot k is not priv, not branch, not hilo, and has mem_type==`MEM_NOOP;
  - no slot j<k is priv;
  - its sources are not busy in the scoreboard, same rule as slot 0;
  - RAW check: for every j<k with wb_en_j && dest_j!=0, dest_j != rs_k, and dest_j != rt_k when opcode_k==0;
  - WAW check: for every j<k with wb_en_j && wb_en_k && dest_j!=0, dest_j != dest_k.
- Once slot k fails, all higher slots fail, so the mask is always a prefix.
- Perf counters increment on the edge by the rules listed in Ports; they are not affected by stall or flush and wrap at 2^PERF_WIDTH.
- With ISSUE_WIDTH=1 the engine degenerates to a single-issue load-use detector; perf_multi_cnt stays 0.

Test Plan:
1. Reset mid-run with scoreboard entries set -> scoreboard and perf counters are 0 immediately; a load-dependent slot 0 issues on the first cycle after release.
2. W=2, LOAD_LATENCY=2: slot 0 = lw $5 issues, next cycle slot 0 = addu $6,$5,$1 -> load_use_stall=1 for 2 cycles, issue_count=1 on the 3rd cycle.
3. W=2: slot 0 writes $3, slot 1 = addu $4,$3,$2 -> issue_mask=01. Change slot 1's rs to $7 -> issue_mask=11, and perf_multi_cnt increments by 1.
4. W=4, fifo_count=3, four independent ALU ops -> issue_mask=0111, issue_count=3.
5. W=4, slot 2 is a branch -> issue_mask=0011. Slot 0 priv -> issue_mask=0001.
6. Scoreboard $5 busy, then flush -> counter cleared on that edge; next cycle addu using $5 in slot 0 issues. Stall held for 3 cycles -> counter value unchanged.
